// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard peripheral: receiver states,
// register offsets and STATUS field positions.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [3:0] KBD_DATA_OFS   = 4'h0;
    localparam logic [3:0] KBD_STATUS_OFS = 4'h4;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_ERR   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // When full, push+pop writes the slot being popped; the head was already read out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver with scan-code FIFO and CPU register window.
// Optional odd-parity checking is enabled by defining KBD_PARITY_CHECK_EN.
module ps2_kbd
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        sel,
    input  logic        re,
    input  logic [3:0]  addr,
    output logic [31:0] dout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   data_bit;

    rx_state_t state;
    rx_state_t next;
    logic [2:0]    cnt;
    logic [7:0]    shreg;
    logic [TW-1:0] tmr;
    logic          push;
    logic          pop;
    logic          clr;
    logic          ovf;
    logic          err;
    logic          full;
    logic          empty;
    logic [7:0]    head;
    logic [3:0]    status;

    // Lines idle high, so reset the synchronizers to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync[0]  <= ps2_clk;
            data_sync[0] <= ps2_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync[i]  <= clk_sync[i-1];
                data_sync[i] <= data_sync[i-1];
            end
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_bit = data_sync[SYNC_STAGES-1];

`ifdef KBD_PARITY_CHECK_EN
    logic par;
    logic frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         par <= 1'b0;
        else if (fall && state == PARITY) par <= data_bit;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        push = 1'b0;
`ifdef KBD_PARITY_CHECK_EN
        frame_err = 1'b0;
`endif
        if (state != IDLE && !fall && tmr == TW'(TIMEOUT_CYCLES - 1)) begin
            next = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:   if (!data_bit) next = DATA;
                DATA:   if (cnt == 3'd7) next = PARITY;
                PARITY: next = STOP;
                STOP: begin
                    next = IDLE;
`ifdef KBD_PARITY_CHECK_EN
                    // Odd parity: data bits plus parity bit hold an odd number of ones.
                    if (data_bit && (^{shreg, par})) push = 1'b1;
                    else                             frame_err = 1'b1;
`else
                    push = data_bit;
`endif
                end
                default: next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            shreg <= '0;
            tmr   <= '0;
        end else begin
            tmr <= (fall || state == IDLE) ? '0 : tmr + 1'b1;
            if (fall) begin
                case (state)
                    IDLE: cnt <= '0;
                    DATA: begin
                        shreg <= {data_bit, shreg[7:1]};
                        cnt   <= cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pop = sel & re & (addr == KBD_DATA_OFS) & ~empty;
    assign clr = sel & re & (addr == KBD_STATUS_OFS);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (shreg),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Sticky bits: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf <= 1'b0;
        else     ovf <= (push & full & ~pop) | (ovf & ~clr);
    end

`ifdef KBD_PARITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else     err <= frame_err | (err & ~clr);
    end
`else
    assign err = 1'b0;
`endif

    always_comb begin
        status           = '0;
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_OVF]   = ovf;
        status[ST_ERR]   = err;
    end

    always_comb begin
        dout = '0;
        case (addr)
            KBD_DATA_OFS:   dout = {23'b0, ~empty, (empty ? 8'h00 : head)};
            KBD_STATUS_OFS: dout = {28'b0, status};
            default:        dout = '0;
        endcase
    end

endmodule

// File: tb/tb_ps2_kbd.sv
// Self-checking bench for ps2_kbd: table of single frames plus hand-written
// sequences, checked against a queue-based FIFO model.
module tb_ps2_kbd;
    import kbd_pkg::*;

    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
    localparam int TO    = 300;
    localparam int H     = 6;
`ifdef KBD_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        sel = 1'b0;
    logic        re = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] dout;

    always #5 clk = ~clk;

    ps2_kbd #(
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .sel      (sel),
        .re       (re),
        .addr     (addr),
        .dout     (dout)
    );

    typedef struct {
        logic [7:0]  code;
        bit          bp;
        bit          bs;
        logic [31:0] st;
        logic [31:0] dat;
    } vec_t;

    vec_t       tbl [6];
    int         total = 0;
    int         bad = 0;
    logic [7:0] mq [$];
    bit         m_ovf = 1'b0;
    bit         m_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; re = 1'b1; addr = a;
        #1 d = dout;
        @(negedge clk);
        sel = 1'b0; re = 1'b0; addr = 4'h0;
    endtask

    task automatic rd_data(input string nm);
        logic [31:0] d;
        logic [31:0] e;
        e = 32'h0;
        if (mq.size() > 0) e = {23'b0, 1'b1, mq[0]};
        rd(KBD_DATA_OFS, d);
        if (mq.size() > 0) void'(mq.pop_front());
        chk(nm, d, e);
    endtask

    task automatic rd_stat(input string nm);
        logic [31:0] d;
        logic [31:0] e;
        e = {28'b0, m_err, m_ovf, (mq.size() == DEPTH), (mq.size() == 0)};
        rd(KBD_STATUS_OFS, d);
        m_err = 1'b0;
        m_ovf = 1'b0;
        chk(nm, d, e);
    endtask

    task automatic model(input logic [7:0] c, input bit bp, input bit bs);
        if (!bs && !(PAR_EN && bp)) begin
            if (mq.size() < DEPTH) mq.push_back(c);
            else                   m_ovf = 1'b1;
        end else if (PAR_EN) begin
            m_err = 1'b1;
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_body(input logic [7:0] c, input bit bp);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(c[i]);
        ps2_bit((~^c) ^ bp);
    endtask

    task automatic send(input logic [7:0] c, input bit bp, input bit bs);
        send_body(c, bp);
        ps2_bit(~bs);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        model(c, bp, bs);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] e;

        tbl[0] = '{8'h1C, 1'b0, 1'b0, 32'h0, 32'h11C};
        tbl[1] = '{8'hF0, 1'b0, 1'b0, 32'h0, 32'h1F0};
        tbl[2] = '{8'h00, 1'b0, 1'b0, 32'h0, 32'h100};
        tbl[3] = '{8'hFF, 1'b0, 1'b0, 32'h0, 32'h1FF};
        tbl[4] = '{8'h5A, 1'b1, 1'b0, (PAR_EN ? 32'h9 : 32'h0), (PAR_EN ? 32'h0 : 32'h15A)};
        tbl[5] = '{8'h33, 1'b0, 1'b1, (PAR_EN ? 32'h9 : 32'h1), 32'h0};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        rd(KBD_DATA_OFS, d);   chk("rst_data", d, 32'h0);
        rd(KBD_STATUS_OFS, d); chk("rst_stat", d, 32'h1);

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].code, tbl[i].bp, tbl[i].bs);
            rd(KBD_STATUS_OFS, d); chk($sformatf("vec%0d_stat", i), d, tbl[i].st);
            rd(KBD_DATA_OFS, d);   chk($sformatf("vec%0d_data", i), d, tbl[i].dat);
            rd(KBD_STATUS_OFS, d); chk($sformatf("vec%0d_after", i), d, 32'h1);
            mq.delete();
            m_err = 1'b0;
            m_ovf = 1'b0;
        end

        // Overflow: nine frames into an eight-entry FIFO.
        for (int c = 1; c <= 9; c++) send(8'(c), 1'b0, 1'b0);
        rd_stat("ovf_stat");
        for (int i = 0; i < DEPTH; i++) rd_data($sformatf("ovf_rd%0d", i));
        rd_stat("ovf_clr");

        // Stall mid-frame past the timeout, then a clean frame.
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO + 50) @(negedge clk);
        send(8'hF0, 1'b0, 1'b0);
        rd_data("to_data");
        rd_stat("to_stat");

        // Full FIFO: DATA read lands in the same cycle as the stop-bit push.
        for (int c = 8'h10; c <= 8'h17; c++) send(8'(c), 1'b0, 1'b0);
        send_body(8'h18, 1'b0);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (SYNC) @(negedge clk);
        e = {23'b0, 1'b1, mq[0]};
        sel = 1'b1; re = 1'b1; addr = KBD_DATA_OFS;
        #1 d = dout;
        @(negedge clk);
        sel = 1'b0; re = 1'b0;
        void'(mq.pop_front());
        mq.push_back(8'h18);
        chk("pp_head", d, e);
        repeat (H - SYNC - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
        rd_stat("pp_stat");
        for (int i = 0; i < DEPTH; i++) rd_data($sformatf("pp_rd%0d", i));
        rd_stat("pp_empty");

        // Reset with three entries queued and a frame in flight.
        send(8'h41, 1'b0, 1'b0);
        send(8'h42, 1'b0, 1'b0);
        send(8'h43, 1'b0, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_err = 1'b0;
        m_ovf = 1'b0;
        ps2_data = 1'b1;
        rd_data("rstm_data");
        rd_stat("rstm_stat");
        send(8'h2A, 1'b0, 1'b0);
        rd(4'h8, d); chk("other_ofs", d, 32'h0);
        rd_data("rstm_next");
        rd_stat("rstm_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_kbd.md
# ps2_kbd

Keyboard peripheral that receives PS/2 scan-code frames from the keyboard, buffers the bytes in a FIFO, and answers CPU loads in the keyboard address window. It is the responder behind the memory map's keyboard select, and it drives the keyboard read-data input of the MMU read mux. The design uses one system clock. The PS/2 lines are treated as asynchronous inputs.

## Interface
Parameters:
- FIFO_DEPTH, 8: number of scan-code entries; must be a power of two and at least 2.
- SYNC_STAGES, 2: number of synchronizer flops on ps2_clk and ps2_data.
- TIMEOUT_CYCLES, 50000: number of idle clk cycles mid-frame before the receiver aborts the frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock from the keyboard.
- ps2_data  in  1  raw PS/2 data from the keyboard.
- sel  in  1  keyboard window select from the MMU.
- re  in  1  load strobe; high for exactly one cycle per CPU load.
- addr  in  4  byte offset within the window (CPU addr[3:0]).
- dout  out  32  read data, combinational from registered state.

## Operation
- The two PS/2 inputs pass through SYNC_STAGES flops. A falling edge is detected when the registered previous sample of ps2_clk is 1 and the current sample is 0.
- Receiver FSM states: IDLE, DATA, PARITY, STOP. Every transition happens only on a detected falling edge, except the timeout.
  - IDLE: if the sampled data bit is 0 (start bit), clear the bit count and go to DATA. If it is 1, stay in IDLE.
  - DATA: shift the bit in, LSB first. After 8 bits, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: if the stop bit is 1 and parity is acceptable, push the byte into the FIFO. In all cases return to IDLE.
  - Timeout: in any state other than IDLE, if TIMEOUT_CYCLES pass with no falling edge, go to IDLE and discard the partial frame. The timeout counter clears on every falling edge.
- FIFO behaviour:
  - A push when the FIFO is full is dropped and sets the sticky bit ovf.
  - Push and pop in the same cycle both take effect, including when the FIFO is full.
  - A pop when the FIFO is empty is ignored.
- Register map (dout is independent of sel; the MMU does the muxing):
  - Offset 0x0, DATA: {23'b0, valid, code[7:0]}. valid = !empty. code is the FIFO head, or 0 when empty. The access sel & re & addr==0 & !empty pops one entry.
  - Offset 0x4, STATUS: {27'b0, err, ovf, full, empty, 1'b0}... is not used. The actual layout is {28'b0, err, ovf, full, empty}. The access sel & re & addr==4 clears err and ovf.
  - Any other offset reads 0 and has no side effects.
- If a clear of a sticky bit and a new setting event happen in the same cycle, the set wins.

## Timing
- Reset values:
  - FSM in IDLE; FIFO empty; ovf = 0 and err = 0.
  - Synchronizer flops reset to 1 (the idle level of the PS/2 lines).
  - dout at reset: DATA reads 0x0000_0000 and STATUS reads 0x0000_0001.
- A falling edge on ps2_clk is seen SYNC_STAGES+1 cycles after it occurs on the pin.
- The FIFO push is registered in the cycle the stop bit is sampled. The byte is visible at DATA in the next cycle.
- A pop (or a sticky-bit clear) changes dout in the cycle after re. The value returned during the re cycle is the value before the pop.
- Asserting rst mid-frame or with a non-empty FIFO discards everything. After reset is released, the first accepted start bit is the first falling edge seen with data = 0.

## Configuration
- Macro: KBD_PARITY_CHECK_EN.
  - Defined: the receiver checks odd parity over the 8 data bits plus the parity bit. On a mismatch, the frame is dropped and err is set.
  - Undefined: the parity bit is captured and ignored, every frame with a good stop bit is pushed, and err is tied to 0.
- A bad stop bit always drops the frame. It sets err only when KBD_PARITY_CHECK_EN is defined.

## Structure
- Package kbd_pkg holds:
  - the receiver state enum (IDLE, DATA, PARITY, STOP);
  - the register offsets KBD_DATA_OFS = 4'h0 and KBD_STATUS_OFS = 4'h4;
  - the bit positions of the STATUS fields.
- Sub-module sync_fifo: parameterized by width and depth. Ports: push, pop, din, dout (head), full, empty. Internal pointers are one bit wider than log2(depth) to distinguish full from empty.
- The top level contains the synchronizers, edge detect, FSM, timeout counter, and register decode.

## Test plan
- Single valid frame for 0x1C (data LSB first, parity 0, stop 1) → DATA reads 0x0000_011C. One DATA read pops it; STATUS then reads 0x1.
- Nine frames 0x01 through 0x09 with no reads (FIFO_DEPTH = 8) → STATUS reads 0x6 (ovf and full). Eight DATA reads return 0x101 through 0x108 in order. Reading STATUS clears ovf.
- Frame with a wrong parity bit → with the macro defined: FIFO stays empty and STATUS reads 0x9. Without the macro: the byte is pushed and err stays 0.
- Frame stalled after 4 data bits for more than TIMEOUT_CYCLES, then a valid 0xF0 frame → only 0xF0 is in the FIFO, and the partial frame leaves no entry.
- FIFO full, with a DATA read in the same cycle as a new push → the head is popped, the new byte is stored, full stays 1, and ovf stays 0.
- rst pulsed while the FIFO holds 3 entries and a frame is in the middle of its data bits → DATA reads 0, STATUS reads 0x1, and the next complete frame is received correctly.
